// File: rtl/ni_inject.sv
// rtl/ni_inject.sv - local-port packet injector with per-VC credit flow control
//
// Purpose: accepts a unicast/multicast send request, emits a head flit in the
// shared router flit format, then streams req_len payload flits, gated by a
// per-VC credit counter that mirrors the router's input-buffer occupancy.
//
// Ports:
//   clk, rst_                 clock, async active-high reset
//   req_valid/req_ready       send request handshake
//   req_mcast, req_dst,
//   req_mdst, req_vch,
//   req_len                   request fields (latched on accept)
//   pay_valid/pay_ready,
//   pay_data                  payload flit handshake
//   flit_valid, flit_out,
//   flit_head, flit_tail      registered flit stream to the router
//   credit_in                 per-VC credit returns
//   err_self                  pulse: self-addressed request dropped
//   cred_err                  sticky: credit returned to a full counter

`ifndef NI_FLIT_FMT
`define NI_FLIT_FMT
`define DATAW    31
`define UADDR    3
`define MADDR    15
`define VCHW     0
`define UM_TYPE  31
`define VCH_MSB  30
`define VCH_LSB  30
`define MDST_MSB 15
`define MDST_LSB 0
`define DST_MSB  3
`define DST_LSB  0
`endif

module ni_inject #(
  parameter int MY_ID    = 0,
  parameter int NUM_VC   = 2,
  parameter int CRED_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_mcast,
  input  logic [`UADDR:0]     req_dst,
  input  logic [`MADDR:0]     req_mdst,
  input  logic [`VCHW:0]      req_vch,
  input  logic [3:0]          req_len,
  input  logic                pay_valid,
  output logic                pay_ready,
  input  logic [`DATAW:0]     pay_data,
  output logic                flit_valid,
  output logic [`DATAW:0]     flit_out,
  output logic                flit_head,
  output logic                flit_tail,
  input  logic [NUM_VC-1:0]   credit_in,
  output logic                err_self,
  output logic                cred_err
);

  localparam int UW = `UADDR + 1;
  localparam int MW = `MADDR + 1;
  localparam int VW = `VCHW + 1;
  localparam int DW = `DATAW + 1;
  localparam logic [3:0]    CMAX     = 4'(CRED_MAX);
  localparam logic [MW-1:0] SELF_BIT = MW'(1) << MY_ID;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t          state_q;
  logic            mcast_q;
  logic [UW-1:0]   dst_q;
  logic [MW-1:0]   mdst_q;
  logic [VW-1:0]   vch_q;
  logic [3:0]      len_q;
  logic [3:0]      rem_q;
  logic [DW-1:0]   flit_q;
  logic            valid_q, head_q, tail_q, err_self_q;
  logic [3:0]      cred_q [NUM_VC];
  logic [3:0]      cred_d [NUM_VC];
  logic            cred_err_q, cred_err_d;

  logic            req_acc, req_self, cred_ok, head_issue, pay_acc, issue;
  logic [MW-1:0]   req_mask;
  logic [DW-1:0]   hdr_flit, pay_flit;

  assign req_ready = !rst_ && (state_q == IDLE);
  assign cred_ok   = (cred_q[vch_q] != 4'd0);
  assign pay_ready = !rst_ && (state_q == BODY) && cred_ok;

  assign req_acc    = req_valid && req_ready;
  assign req_mask   = req_mdst & ~SELF_BIT;
  // A multicast that only names this node collapses to an empty mask.
  assign req_self   = req_mcast ? (req_mask == '0) : (req_dst == UW'(MY_ID));
  assign head_issue = (state_q == HEAD) && cred_ok;
  assign pay_acc    = pay_valid && pay_ready;
  assign issue      = head_issue || pay_acc;

  always_comb begin
    hdr_flit = '0;
    hdr_flit[`UM_TYPE] = mcast_q;
    if (mcast_q) hdr_flit[`MDST_MSB:`MDST_LSB] = mdst_q;
    else         hdr_flit[`DST_MSB:`DST_LSB]   = dst_q;
    hdr_flit[`VCH_MSB:`VCH_LSB] = vch_q;

    // Payload keeps its bits except the routing-relevant type and VC fields.
    pay_flit = pay_data;
    pay_flit[`UM_TYPE] = mcast_q;
    pay_flit[`VCH_MSB:`VCH_LSB] = vch_q;
  end

  // Issue and return on the same VC in one cycle cancel out.
  always_comb begin
    cred_err_d = cred_err_q;
    for (int v = 0; v < NUM_VC; v++) begin
      cred_d[v] = cred_q[v];
      if (credit_in[v] && !(issue && vch_q == VW'(v))) begin
        if (cred_q[v] == CMAX) cred_err_d = 1'b1;
        else                   cred_d[v]  = cred_q[v] + 4'd1;
      end else if (!credit_in[v] && issue && vch_q == VW'(v)) begin
        cred_d[v] = cred_q[v] - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      for (int v = 0; v < NUM_VC; v++) cred_q[v] <= CMAX;
      cred_err_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VC; v++) cred_q[v] <= cred_d[v];
      cred_err_q <= cred_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_q    <= IDLE;
      mcast_q    <= 1'b0;
      dst_q      <= '0;
      mdst_q     <= '0;
      vch_q      <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      flit_q     <= '0;
      valid_q    <= 1'b0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      err_self_q <= 1'b0;
    end else begin
      valid_q    <= issue;
      head_q     <= head_issue;
      tail_q     <= (head_issue && len_q == 4'd0) || (pay_acc && rem_q == 4'd1);
      flit_q     <= head_issue ? hdr_flit : (pay_acc ? pay_flit : '0);
      err_self_q <= req_acc && req_self;
      case (state_q)
        IDLE: begin
          if (req_acc) begin
            mcast_q <= req_mcast;
            dst_q   <= req_dst;
            mdst_q  <= req_mask;
            vch_q   <= req_vch;
            len_q   <= req_len;
            state_q <= req_self ? IDLE : HEAD;
          end
        end
        HEAD: begin
          if (head_issue) begin
            rem_q   <= len_q;
            state_q <= (len_q == 4'd0) ? IDLE : BODY;
          end
        end
        BODY: begin
          if (pay_acc) begin
            rem_q <= rem_q - 4'd1;
            if (rem_q == 4'd1) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign flit_valid = valid_q;
  assign flit_out   = flit_q;
  assign flit_head  = head_q;
  assign flit_tail  = tail_q;
  assign err_self   = err_self_q;
  assign cred_err   = cred_err_q;

endmodule
